rr_grant_scheduler: RTL

//   Four-agent round-robin grant scheduler for a shared single-owner resource.

---
 rtl/rr_grant_scheduler.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/rr_grant_scheduler.sv
// ---------------------------------------------------------------------------
// rr_grant_scheduler
//
// Four-agent round-robin grant scheduler for a shared, single-owner resource.
// Each ownership is capped at QUANTUM cycles. When the quantum expires, the
// owner is preempted. Every release is followed by one idle (turnaround)
// cycle before the next grant. The pointer then moves past the released
// owner, so no requester can starve.
//
// Parameters
//   QUANTUM   max consecutive grant cycles per ownership (0 = unlimited)
//   CNT_W     width of the grant-cycle counter; must be able to hold QUANTUM
//
// Ports
//   clock     in   rising-edge clock
//   reset     in   synchronous, active-high reset
//   req_0..3  in   active-high request per agent
//   gnt_0..3  out  active-high registered grant per agent (one-hot or zero)
//   busy      out  high while any grant is asserted
//   grant_id  out  index of the current or last owner (holds while idle)
//   preempt   out  one-cycle pulse after a grant is revoked by quantum expiry
// ---------------------------------------------------------------------------
module rr_grant_scheduler #(
    parameter int unsigned QUANTUM = 8,
    parameter int unsigned CNT_W   = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       req_0,
    input  logic       req_1,
    input  logic       req_2,
    input  logic       req_3,
    output logic       gnt_0,
    output logic       gnt_1,
    output logic       gnt_2,
    output logic       gnt_3,
    output logic       busy,
    output logic [1:0] grant_id,
    output logic       preempt
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    localparam logic [CNT_W-1:0] QUANTUM_C = CNT_W'(QUANTUM);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam bit               HAS_LIMIT = (QUANTUM != 0);

    // Registered state
    logic [0:0]       state_q,    state_d;
    logic [1:0]       ptr_q,      ptr_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic [3:0]       gnt_q,      gnt_d;
    logic [1:0]       grant_id_q, grant_id_d;
    logic             preempt_q,  preempt_d;

    // Arbitration signals
    logic [3:0] req_vec;
    logic [1:0] cand;
    logic       arb_found;
    logic [1:0] arb_sel;
    logic       owner_req;
    logic       quantum_hit;

    assign req_vec = {req_3, req_2, req_1, req_0};

    // Round-robin search: the first requester found, starting at ptr_q and
    // wrapping modulo 4, wins the grant.
    // NOTE: every variable gets a default at the top of always_comb. If a
    // path leaves one unassigned, synthesis infers a latch.
    always_comb begin
        arb_found = 1'b0;
        arb_sel   = ptr_q;
        cand      = ptr_q;
        for (int i = 0; i < 4; i++) begin
            cand = ptr_q + 2'(i);
            if (!arb_found && req_vec[cand]) begin
                arb_found = 1'b1;
                arb_sel   = cand;
            end
        end
    end

    // Owner-side conditions that are evaluated while in GRANT.
    assign owner_req   = req_vec[grant_id_q];
    assign quantum_hit = HAS_LIMIT && (cnt_q == QUANTUM_C);

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        gnt_d      = gnt_q;
        grant_id_d = grant_id_q;
        preempt_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Requests from non-owners are only considered here. This
                // also guarantees the turnaround cycle after any release.
                if (arb_found) begin
                    state_d    = ST_GRANT;
                    gnt_d      = 4'b0001 << arb_sel;
                    grant_id_d = arb_sel;
                    cnt_d      = CNT_ONE;
                end
            end

            ST_GRANT: begin
                if (!owner_req || quantum_hit) begin
                    // A voluntary release takes priority over expiry. When
                    // both happen on the same edge, the owner is simply done
                    // and no preempt pulse is raised.
                    state_d   = ST_IDLE;
                    gnt_d     = '0;
                    cnt_d     = '0;
                    ptr_d     = grant_id_q + 2'd1;
                    preempt_d = owner_req;
                end else if (cnt_q != CNT_MAX) begin
                    // Saturation only matters for QUANTUM=0. Otherwise the
                    // quantum check releases the grant before the counter
                    // can reach its maximum value.
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments, so every register
    // samples the values from before the edge. Blocking assignments here would
    // create order-dependent simulation races.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            cnt_q      <= '0;
            gnt_q      <= '0;
            grant_id_q <= '0;
            preempt_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            gnt_q      <= gnt_d;
            grant_id_q <= grant_id_d;
            preempt_q  <= preempt_d;
        end
    end

    assign gnt_0    = gnt_q[0];
    assign gnt_1    = gnt_q[1];
    assign gnt_2    = gnt_q[2];
    assign gnt_3    = gnt_q[3];
    assign busy     = |gnt_q;
    assign grant_id = grant_id_q;
    assign preempt  = preempt_q;

endmodule
